// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/sequencing logic.
package riscv_pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  // Youngest producer wins; x0 is hardwired zero so it never forwards.
  function automatic fwd_sel_t fwd_select(
    input logic       use_src,
    input logic [4:0] src,
    input logic       ex_fwd_ok,
    input logic [4:0] ex_rd,
    input logic       mem_reg_write,
    input logic [4:0] mem_rd,
    input logic       wb_reg_write,
    input logic [4:0] wb_rd
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_src && (src != 5'd0)) begin
      if (ex_fwd_ok && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_reg_write && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection and ID-stage operand forwarding selects.
module hazard_fwd_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic [1:0] ex_wb_sel,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic       load_use,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  logic ex_is_load;
  logic ex_fwd_ok;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    ex_is_load = ex_reg_write && (ex_wb_sel == WB_SEL_LOAD) && (ex_rd != 5'd0);
    // Load data is not available until MEM, so EX may only forward non-load results.
    ex_fwd_ok  = ex_reg_write && (ex_wb_sel != WB_SEL_LOAD);
    rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
    load_use   = ex_is_load && (rs1_hit || rs2_hit);

    fwd_a_sel = fwd_select(id_use_rs1, id_rs1, ex_fwd_ok, ex_rd,
                           mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    fwd_b_sel = fwd_select(id_use_rs2, id_rs2, ex_fwd_ok, ex_rd,
                           mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: stall/flush priority, data-memory wait FSM with
// timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_wb_sel,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  perf_q, perf_d;

  logic load_use;
  logic mem_stall;
  logic stall_now;

  hazard_fwd_unit u_hazard_fwd_unit (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_wb_sel     (ex_wb_sel),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .load_use      (load_use),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel)
  );

  always_comb begin
    mem_stall = dmem_req && !dmem_ready;
    // Once waiting, the frozen MEM stage keeps its access open until ready.
    stall_now = (state_q == MEM_WAIT) ? !dmem_ready : mem_stall;
  end

  always_comb begin
    pc_en           = 1'b1;
    pc_sel_redirect = 1'b0;
    if_id_en        = 1'b1;
    id_ex_en        = 1'b1;
    ex_mem_en       = 1'b1;
    mem_wb_en       = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    mem_wb_flush    = 1'b0;
    if (!resetn) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (stall_now) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      // The dependent instruction in ID is squashed, so load_use is moot here.
      pc_sel_redirect = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    perf_d     = perf_q;

    unique case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (mem_stall) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (!pc_en && (perf_q != {CNT_W{1'b1}})) begin
      perf_d = perf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      perf_q     <= perf_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign perf_stall_cnt  = perf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: control/forwarding vector table plus
// multi-cycle sequences for load-use, memory wait, timeout and reset.
module tb_pipeline_hazard_ctrl;
  import riscv_pipe_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  // {pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //  if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [8:0] CTL_NORM  = 9'b1_0_1111_000;
  localparam logic [8:0] CTL_LU    = 9'b0_0_0111_010;
  localparam logic [8:0] CTL_REDIR = 9'b1_1_1111_110;
  localparam logic [8:0] CTL_STALL = 9'b0_0_0001_001;
  localparam logic [8:0] CTL_RST   = 9'b1_0_1111_111;

  logic clk = 1'b0;
  logic resetn;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
  logic [1:0] ex_wb_sel;
  logic ex_redirect, dmem_req, dmem_ready;
  logic pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] perf_stall_cnt;
  logic [8:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_wb_sel       (ex_wb_sel),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_reg_write    (wb_reg_write),
    .ex_redirect     (ex_redirect),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .pc_sel_redirect (pc_sel_redirect),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_flush    (mem_wb_flush),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .mem_timeout_err (mem_timeout_err),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       exrw;
    logic [1:0] exwb;
    logic [4:0] memrd;
    logic       memrw;
    logic [4:0] wbrd;
    logic       wbrw;
    logic       redir, req, rdy;
    logic [8:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int exrd, int exrw, int exwb,
                              int memrd, int memrw, int wbrd, int wbrw, int redir, int req,
                              int rdy, logic [8:0] c, int fa, int fb);
    vec_t v;
    v.rs1 = 5'(rs1);     v.rs2 = 5'(rs2);   v.u1 = 1'(u1);       v.u2 = 1'(u2);
    v.exrd = 5'(exrd);   v.exrw = 1'(exrw); v.exwb = 2'(exwb);
    v.memrd = 5'(memrd); v.memrw = 1'(memrw);
    v.wbrd = 5'(wbrd);   v.wbrw = 1'(wbrw);
    v.redir = 1'(redir); v.req = 1'(req);   v.rdy = 1'(rdy);
    v.ctl = c;           v.fa = 2'(fa);     v.fb = 2'(fb);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1;  id_rs2 = v.rs2;  id_use_rs1 = v.u1;  id_use_rs2 = v.u2;
    ex_rd = v.exrd;  ex_reg_write = v.exrw;  ex_wb_sel = v.exwb;
    mem_rd = v.memrd;  mem_reg_write = v.memrw;
    wb_rd = v.wbrd;  wb_reg_write = v.wbrw;
    ex_redirect = v.redir;  dmem_req = v.req;  dmem_ready = v.rdy;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NORM, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NORM, 0, 0);
    vecs[1]  = mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_LU, 0, 0);
    vecs[2]  = mk(3, 5, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_LU, 0, 0);
    vecs[3]  = mk(5, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_NORM, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_NORM, 0, 0);
    vecs[5]  = mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, CTL_REDIR, 0, 0);
    vecs[6]  = mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0, CTL_STALL, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, CTL_NORM, 0, 0);
    vecs[8]  = mk(7, 7, 1, 1, 7, 1, 0, 7, 1, 7, 1, 0, 0, 0, CTL_NORM, 1, 1);
    vecs[9]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, CTL_NORM, 0, 0);
    vecs[10] = mk(7, 9, 1, 1, 3, 1, 0, 7, 1, 9, 1, 0, 0, 0, CTL_NORM, 2, 3);
    vecs[11] = mk(7, 7, 1, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, CTL_NORM, 2, 0);
    vecs[12] = mk(8, 0, 1, 0, 8, 1, 1, 8, 1, 0, 0, 0, 0, 0, CTL_LU, 2, 0);
    vecs[13] = mk(4, 4, 1, 1, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0, CTL_NORM, 1, 1);
    vecs[14] = mk(6, 6, 1, 1, 0, 0, 0, 6, 0, 6, 0, 0, 0, 0, CTL_NORM, 0, 0);

    // Reset state: outputs forced during reset, counters cleared after.
    resetn = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    chk("reset ctl", 32'(ctl), 32'(CTL_RST));
    do_reset();
    @(negedge clk);
    chk("reset err", 32'(mem_timeout_err), 32'd0);
    chk("reset perf", 32'(perf_stall_cnt), 32'd0);

    // Combinational table, each vector applied fresh out of reset in RUN.
    for (int i = 0; i < 15; i++) begin
      do_reset();
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d fwd_a", i), 32'(fwd_a_sel), 32'(vecs[i].fa));
      chk($sformatf("vec%0d fwd_b", i), 32'(fwd_b_sel), 32'(vecs[i].fb));
    end

    // Load x5 in EX, add x6,x5,x1 in ID: one bubble, then MEM forward.
    do_reset();
    drive(mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, CTL_NORM, 0, 0));
    @(negedge clk);
    chk("lu stall pc_en", 32'(pc_en), 32'd0);
    chk("lu stall id_ex_flush", 32'(id_ex_flush), 32'd1);
    step();
    drive(mk(5, 1, 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, CTL_NORM, 0, 0));
    @(negedge clk);
    chk("lu next fwd_a", 32'(fwd_a_sel), 32'(FWD_MEM));
    chk("lu next perf", 32'(perf_stall_cnt), 32'd1);
    chk("lu next ctl", 32'(ctl), 32'(CTL_NORM));

    // Three-cycle memory wait with a redirect held behind the frozen EX stage.
    do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, CTL_NORM, 0, 0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mw frozen c%0d", c), 32'(ctl), 32'(CTL_STALL));
      step();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("mw exit ctl", 32'(ctl), 32'(CTL_REDIR));
    step();
    drive(vecs[0]);
    @(negedge clk);
    chk("mw after ctl", 32'(ctl), 32'(CTL_NORM));
    chk("mw after state", 32'(dut.state_q), 32'(RUN));
    chk("mw after perf", 32'(perf_stall_cnt), 32'd3);
    chk("mw after err", 32'(mem_timeout_err), 32'd0);

    // Timeout: ready never arrives; error is sticky and perf count saturates.
    do_reset();
    dmem_req = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("to early err", 32'(mem_timeout_err), 32'd0);
    repeat (2) step();
    @(negedge clk);
    chk("to set err", 32'(mem_timeout_err), 32'd1);
    repeat (15) step();
    @(negedge clk);
    chk("to sticky err", 32'(mem_timeout_err), 32'd1);
    chk("to still stalled", 32'(ctl), 32'(CTL_STALL));
    chk("to perf saturated", 32'(perf_stall_cnt), 32'hF);
    resetn = 1'b0;
    @(negedge clk);
    chk("to reset ctl", 32'(ctl), 32'(CTL_RST));
    step();
    resetn = 1'b1;
    dmem_req = 1'b0;
    @(negedge clk);
    chk("to cleared err", 32'(mem_timeout_err), 32'd0);
    chk("to cleared perf", 32'(perf_stall_cnt), 32'd0);

    // Reset mid MEM_WAIT returns to RUN with normal outputs.
    do_reset();
    dmem_req = 1'b1;
    repeat (2) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    dmem_req = 1'b0;
    @(negedge clk);
    chk("rst mid state", 32'(dut.state_q), 32'(RUN));
    chk("rst mid ctl", 32'(ctl), 32'(CTL_NORM));
    chk("rst mid perf", 32'(perf_stall_cnt), 32'd0);
    chk("rst mid err", 32'(mem_timeout_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
